dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory. Port 0 is the CPU MEM stage; port 1 is the test/DMA loader.
- Each port gets a req/gnt/rvalid handshake. Requests are resolved round-robin and issued to memory as one read or write strobe.
- The read word, or a write acknowledgement, is returned to the winning port.
- Memory-side outputs connect directly to the data memory's addr/write_data/memwrite/memread/read_data.

Parameters:
- DATA_W, 32, data word width on all ports.
- ADDR_W, 32, address width on all ports. Addresses are word indices.
- DEPTH, 256, number of memory words. Any address >= DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request. Held high until gnt0.
- we0  in  1  port 0 write enable (1 = write, 0 = read). Held with req0.
- addr0  in  ADDR_W  port 0 word address. Held with req0.
- wdata0  in  DATA_W  port 0 write data. Held with req0.
- gnt0  out  1  one-cycle pulse: port 0 request accepted and latched.
- rvalid0  out  1  one-cycle pulse: port 0 access complete.
- rdata0  out  DATA_W  port 0 read data. Valid when rvalid0=1 and we=0.
- err0  out  1  pulses with rvalid0 when the address was out of range.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: identical to port 0, for port 1.
- mem_addr  out  ADDR_W  address driven to memory.
- mem_wdata  out  DATA_W  write data driven to memory.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0) clears all outputs to 0 immediately, including mem_*, gnt*, rvalid*, rdata*, err*.
  - State goes to IDLE and last_grant goes to 1, so port 0 wins the first tie.
  - Any in-flight access is abandoned and produces no rvalid after release.
- FSM states are IDLE, ACCESS, RESP. All outputs are registered.
- IDLE, with any req sampled high at edge k:
  - Pick the winner. If only one port requests, it wins. If both request, the port != last_grant wins.
  - Latch the winner's we/addr/wdata and update last_grant.
  - Go to ACCESS. The winner's gnt is high for the cycle after edge k.
  - The losing request stays pending. It is not dropped and receives no gnt.
- ACCESS, exactly 1 cycle:
  - mem_addr and mem_wdata carry the latched values.
  - mem_write = latched we and mem_read = !latched we, both only if the address is in range. Otherwise both stay 0.
  - Go to RESP.
- RESP, exactly 1 cycle:
  - mem_write and mem_read = 0. mem_addr holds its value, so no spurious address change is presented to memory.
  - Winner's rvalid = 1.
  - Read in range: rdata <= mem_rdata, sampled at the ACCESS->RESP edge.
  - Out of range: err = 1 and rdata <= 0.
  - Write: rdata is unchanged.
  - Go to IDLE.
- Latency: req sampled at edge k gives gnt in cycle k+1, rvalid in cycle k+2, and the next arbitration at edge k+3. Maximum throughput is one access per 3 cycles.
- After gnt, the requester may change req/addr/wdata freely. Holding req high after gnt is treated as a new request.
- gnt0/gnt1 and rvalid0/rvalid1 are mutually exclusive. Never both high.
- Starvation bound: a continuously asserted request is granted within 2 arbitration rounds, i.e. 6 cycles.
- rdata0/rdata1 hold their last value between accesses.

Test Plan:
- Reset then single read:
  - Stimulus: rst_n low 2 cycles. Port 0 reads addr0=6 with mem model DMEM[6]=6.
  - Required: gnt0 in cycle 1, mem_read=1 with mem_addr=6 in cycle 1, rvalid0=1 and rdata0=6 in cycle 2, err0=0.
- Write then read:
  - Stimulus: port 1 writes wdata1=32'hDEADBEEF to addr1=10, then reads addr1=10.
  - Required: mem_write pulses once with mem_addr=10. The read returns rdata1=32'hDEADBEEF.
- Simultaneous requests held high for 4 rounds:
  - Required: grants alternate 0,1,0,1. gnt and rvalid are never both high across ports.
- Out of range:
  - Stimulus: port 0 reads addr0=256.
  - Required: mem_read and mem_write stay 0, rvalid0=1 with err0=1 and rdata0=0.
- Reset mid-operation:
  - Stimulus: assert rst_n low during ACCESS of a write.
  - Required: mem_write drops to 0 asynchronously. No rvalid after release. Next simultaneous request grants port 0 first.
- Back-to-back holding:
  - Stimulus: port 0 keeps req0 high for 3 accesses with port 1 idle.
  - Required: gnt0 every 3 cycles, 3 rvalid0 pulses.

Source files
------------

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port round-robin arbiter and sequencer in front of a
//            single-ported data memory. Port 0 is the CPU MEM stage, port 1
//            the test/DMA loader. Each access runs IDLE -> ACCESS -> RESP.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0 (CPU)
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  // port 1 (loader)
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);

  state_t r_state;
  state_t w_state_nxt;

  logic r_last_grant;  // port that won the previous arbitration
  logic r_port;        // port owning the access in flight
  logic r_we;          // latched write enable of the access in flight
  logic r_oor;         // latched out-of-range flag of the access in flight

  logic              w_start;
  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_in_range;

  // Operands of whichever port wins this cycle's arbitration.
  assign w_sel_we    = w_win ? we1    : we0;
  assign w_sel_addr  = w_win ? addr1  : addr0;
  assign w_sel_wdata = w_win ? wdata1 : wdata0;
  assign w_in_range  = (w_sel_addr < c_depth);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and round-robin winner selection (ties go to the port that
  // did not win last time).
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_win       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_start     = 1'b1;
          w_win       = (req0 && req1) ? ~r_last_grant : req1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: grant/strobes on arbitration, response on ACCESS exit.
  // mem_addr/mem_wdata double as the latched request and hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_oor        <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;

      if (w_start) begin
        r_last_grant <= w_win;
        r_port       <= w_win;
        r_we         <= w_sel_we;
        r_oor        <= ~w_in_range;
        gnt0         <= ~w_win;
        gnt1         <= w_win;
        mem_addr     <= w_sel_addr;
        mem_wdata    <= w_sel_wdata;
        mem_write    <= w_sel_we & w_in_range;
        mem_read     <= ~w_sel_we & w_in_range;
      end

      if (r_state == S_ACCESS) begin
        if (r_port == 1'b0) begin
          rvalid0 <= 1'b1;
          err0    <= r_oor;
          if (r_oor)      rdata0 <= '0;
          else if (!r_we) rdata0 <= mem_rdata;
        end else begin
          rvalid1 <= 1'b1;
          err1    <= r_oor;
          if (r_oor)      rdata1 <= '0;
          else if (!r_we) rdata1 <= mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios plus a
//            randomized phase, all checked against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Data memory environment: combinational read, write on the clock edge.
  // Out-of-range reads return garbage so a leak into rdata is visible.
  logic [31:0] mem [0:DEPTH-1];
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_write && mem_addr < DEPTH) mem[mem_addr[7:0]] = mem_wdata;

  // Reference model: a transaction timeline. An accepted request occupies the
  // memory for three cycles (grant, response, turnaround); its effect on the
  // shadow memory and the returned word are computed from the rules directly.
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        e_gnt [2], e_rvalid [2], e_err [2];
  logic [31:0] e_rdata [2];
  logic [31:0] e_addr, e_wdata;
  logic        e_read, e_write;
  int          cycles_left;
  int          last_win, m_port;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        e_gnt[i] = 0; e_rvalid[i] = 0; e_err[i] = 0; e_rdata[i] = '0;
      end
      e_addr = '0; e_wdata = '0; e_read = 0; e_write = 0;
      cycles_left = 0; last_win = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_gnt[i] = 0; e_rvalid[i] = 0; e_err[i] = 0;
      end
      e_read = 0; e_write = 0;
      if (cycles_left == 2) begin
        e_rvalid[m_port] = 1;
        if (m_addr >= DEPTH) begin
          e_err[m_port]   = 1;
          e_rdata[m_port] = '0;
        end else if (m_we) begin
          ref_mem[m_addr[7:0]] = m_wdata;
        end else begin
          e_rdata[m_port] = ref_mem[m_addr[7:0]];
        end
        cycles_left = 1;
      end else if (cycles_left == 1) begin
        cycles_left = 0;
      end else if (req0 || req1) begin
        if (req0 && req1) m_port = (last_win == 0) ? 1 : 0;
        else              m_port = req1 ? 1 : 0;
        last_win = m_port;
        m_we    = m_port ? we1 : we0;
        m_addr  = m_port ? addr1 : addr0;
        m_wdata = m_port ? wdata1 : wdata0;
        e_gnt[m_port] = 1;
        e_addr  = m_addr;
        e_wdata = m_wdata;
        e_write = m_we && (m_addr < DEPTH);
        e_read  = !m_we && (m_addr < DEPTH);
        cycles_left = 2;
      end
    end
  end

  // Every cycle, mid-period: compare all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk_eq("gnt0", gnt0, e_gnt[0]);
      chk_eq("gnt1", gnt1, e_gnt[1]);
      chk_eq("rvalid0", rvalid0, e_rvalid[0]);
      chk_eq("rvalid1", rvalid1, e_rvalid[1]);
      chk_eq("err0", err0, e_err[0]);
      chk_eq("err1", err1, e_err[1]);
      chk_eq("rdata0", rdata0, e_rdata[0]);
      chk_eq("rdata1", rdata1, e_rdata[1]);
      chk_eq("mem_read", mem_read, e_read);
      chk_eq("mem_write", mem_write, e_write);
      chk_eq("mem_addr", mem_addr, e_addr);
      chk_eq("mem_wdata", mem_wdata, e_wdata);
      chk_eq("gnt_excl", gnt0 & gnt1, 0);
      chk_eq("rvalid_excl", rvalid0 & rvalid1, 0);
    end
  end

  int wr10_count = 0;
  always @(negedge clk) if (mem_write && mem_addr == 32'd10) wr10_count++;

  function automatic logic [31:0] rnd_addr();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return 32'd256 + 32'($urandom_range(0, 300));
    if (sel == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 15));
  endfunction

  // Issue one request from a negedge, wait (bounded) for the grant, then
  // return the response seen in the following cycle.
  task automatic issue(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n = 0;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? gnt0 : gnt1) && n < 20);
    chk_eq("issue_gnt", (p == 0) ? gnt0 : gnt1, 1);
    if (p == 0) req0 = 0; else req1 = 0;
    @(negedge clk);
    chk_eq("issue_rvalid", (p == 0) ? rvalid0 : rvalid1, 1);
    rd = (p == 0) ? rdata0 : rdata1;
    er = (p == 0) ? err0 : err1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          wc, rv, order[$], gcyc[$], w0, w1;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst_gnt0", gnt0, 0);
    chk_eq("rst_rvalid1", rvalid1, 0);
    chk_eq("rst_mem_read", mem_read, 0);
    chk_eq("rst_mem_addr", mem_addr, 0);
    chk_eq("rst_rdata0", rdata0, 0);

    // Single read of addr 6, cycle-exact
    rst_n = 1; req0 = 1; we0 = 0; addr0 = 32'd6;
    @(negedge clk);
    chk_eq("rd6_gnt0", gnt0, 1);
    chk_eq("rd6_mem_read", mem_read, 1);
    chk_eq("rd6_mem_addr", mem_addr, 6);
    req0 = 0;
    @(negedge clk);
    chk_eq("rd6_rvalid0", rvalid0, 1);
    chk_eq("rd6_rdata0", rdata0, 6);
    chk_eq("rd6_err0", err0, 0);
    @(negedge clk);

    // Write then read back through port 1
    wc = wr10_count;
    issue(1, 1'b1, 32'd10, 32'hDEADBEEF, rd, er);
    chk_eq("wr10_pulses", wr10_count - wc, 1);
    issue(1, 1'b0, 32'd10, 32'h0, rd, er);
    chk_eq("rd10_data", rd, 32'hDEADBEEF);

    // Out of range read
    issue(0, 1'b0, 32'd256, 32'h0, rd, er);
    chk_eq("oor_err", er, 1);
    chk_eq("oor_rdata", rd, 0);

    // Reset during ACCESS of a write
    req1 = 1; we1 = 1; addr1 = 32'd20; wdata1 = 32'h1234_5678;
    @(negedge clk);
    chk_eq("midrst_write_on", mem_write, 1);
    req1 = 0;
    #2 rst_n = 0;
    #1;
    chk_eq("midrst_write_off", mem_write, 0);
    chk_eq("midrst_gnt1", gnt1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) rv++;
    end
    chk_eq("midrst_no_rvalid", rv, 0);

    // Simultaneous requests held for four rounds: 0,1,0,1
    req0 = 1; we0 = 0; addr0 = 32'd1;
    req1 = 1; we1 = 0; addr1 = 32'd2;
    for (int c = 0; c < 30 && order.size() < 4; c++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk_eq("rr_rounds", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk_eq("rr_order", order[i], i % 2);
    repeat (3) @(negedge clk);

    // Back-to-back holding on port 0
    req0 = 1; we0 = 0; addr0 = 32'd3;
    rv = 0;
    for (int c = 0; c < 20 && gcyc.size() < 3; c++) begin
      @(negedge clk);
      if (gnt0) gcyc.push_back(c);
      if (rvalid0) rv++;
    end
    req0 = 0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid0) rv++;
    end
    chk_eq("b2b_gnts", gcyc.size(), 3);
    for (int i = 1; i < gcyc.size(); i++) chk_eq("b2b_spacing", gcyc[i] - gcyc[i-1], 3);
    chk_eq("b2b_rvalids", rv, 3);
    @(negedge clk);

    // Randomized traffic; requests are held until granted
    w0 = 0; w1 = 0;
    repeat (600) begin
      @(negedge clk);
      if (req0 && gnt0) begin
        chk_eq("starve0", w0 <= 6, 1);
        w0 = 0;
        if ($urandom_range(0, 1) == 1) begin
          we0 = 1'($urandom_range(0, 1)); addr0 = rnd_addr(); wdata0 = $urandom;
        end else req0 = 0;
      end else if (req0) w0++;
      else if ($urandom_range(0, 9) < 4) begin
        req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = rnd_addr(); wdata0 = $urandom; w0 = 0;
      end
      if (req1 && gnt1) begin
        chk_eq("starve1", w1 <= 6, 1);
        w1 = 0;
        if ($urandom_range(0, 1) == 1) begin
          we1 = 1'($urandom_range(0, 1)); addr1 = rnd_addr(); wdata1 = $urandom;
        end else req1 = 0;
      end else if (req1) w1++;
      else if ($urandom_range(0, 9) < 4) begin
        req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = rnd_addr(); wdata1 = $urandom; w1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
